// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: clocked self-test sequencer for a 2-input combinational gate.
// Walks the four input combinations in order 00, 01, 10, 11 on {vin2,vin1}.
// Each combination is held for SETTLE_CYCLES+1 cycles before gate_out is
// sampled and compared against a latched 4-bit truth table. After the run,
// a one-cycle done pulse is issued together with the pass verdict and a
// per-combination mismatch vector.
module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected_tt,
    input  logic       gate_out,
    output logic       vin1,
    output logic       vin2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t           state;
    logic [1:0]       index;
    logic [CNT_W-1:0] counter;
    logic [3:0]       tt_latched;

    logic             mismatch;
    logic [3:0]       index_mask;
    logic [3:0]       fail_vec_next;

    // Mismatch vector as it will look after sampling the current combination;
    // the final verdict needs the mismatch from the last sample edge included.
    always_comb begin
        index_mask    = 4'b0001 << index;
        mismatch      = gate_out ^ tt_latched[index];
        fail_vec_next = fail_vec | (mismatch ? index_mask : 4'b0000);
    end

    // Sequencer: accepts a run, walks the combinations, samples and reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= 2'd0;
            counter    <= '0;
            tt_latched <= 4'b0000;
            vin1       <= 1'b0;
            vin2       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    vin1 <= 1'b0;
                    vin2 <= 1'b0;
                    if (start && !abort) begin
                        tt_latched <= expected_tt;
                        fail_vec   <= 4'b0000;
                        pass       <= 1'b0;
                        index      <= 2'd0;
                        counter    <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        vin1     <= 1'b0;
                        vin2     <= 1'b0;
                        fail_vec <= 4'b0000;
                        pass     <= 1'b0;
                        index    <= 2'd0;
                        counter  <= '0;
                    end else if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        fail_vec <= fail_vec_next;
                        if (index != 2'd3) begin
                            index        <= index + 2'd1;
                            {vin2, vin1} <= index + 2'd1;
                            counter      <= SETTLE_LOAD;
                        end else begin
                            state <= FINISH;
                            index <= 2'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            vin1  <= 1'b0;
                            vin2  <= 1'b0;
                            pass  <= (fail_vec_next == 4'b0000);
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    vin1  <= 1'b0;
                    vin2  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Self-test sequencer for a 2-input combinational gate (NOR, NAND, XOR, etc.) instantiated in the design. On `start` it does the following for each of the four input combinations in turn:
- drives the gate's two inputs;
- waits a programmable settle time;
- samples the gate output and compares it to a 4-bit expected truth table.

It then reports a pass/fail verdict and a per-combination mismatch vector. It replaces free-running stimulus with a synthesizable, clocked check usable in both silicon and simulation.

Parameters:
- SETTLE_CYCLES, 2, extra clock cycles each combination is held before the output is sampled (0..255).
- CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a test run; sampled only in IDLE
- abort  input  1  synchronous cancel of a run in progress
- expected_tt  input  4  expected gate output, indexed by {vin2,vin1}; latched on start acceptance
- gate_out  input  1  output of the gate under test
- vin1  output  1  gate input 1 (LSB of combination index)
- vin2  output  1  gate input 2 (MSB of combination index)
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse on normal completion
- pass  output  1  high when the last completed run had no mismatches; held until next start
- fail_vec  output  4  bit i set if combination i mismatched

Behaviour:
Clock and reset:
- One clock domain; reset is asynchronous and active-low (rst_n). All flops clear immediately on rst_n low.
- Reset values: vin1=0, vin2=0, busy=0, done=0, pass=0, fail_vec=0. State = IDLE, index = 0, counter = 0.
- Reset mid-run: abandon the run, no done pulse, all outputs to reset values.

States: IDLE, HOLD, FINISH.
- IDLE:
  - busy=0, vin=00.
  - start=1 at edge E0 (and abort=0): latch expected_tt, clear fail_vec and pass, index=0, counter=SETTLE_CYCLES, drive vin=00, busy=1, go to HOLD.
- HOLD, counter>0: decrement counter.
- HOLD, counter==0 at an edge (sample edge):
  - Compare gate_out with tt_latched[index]; on mismatch set fail_vec[index].
  - If index<3: index+1, drive vin2,vin1 = new index, counter reload, stay in HOLD.
  - If index==3: go to FINISH.
- FINISH (single cycle):
  - busy=0, done=1, vin=00.
  - pass = (final fail_vec==0), including a mismatch captured on the last sample edge.
  - Next edge: IDLE.
- Combination order is vin2,vin1 = 00, 01, 10, 11. Each combination is held SETTLE_CYCLES+1 cycles.
- Sample edges: E0 + k*(SETTLE_CYCLES+1) for k = 1..4.
- done is high in the cycle after the 4th sample edge, i.e. it rises at E0 + 4*(SETTLE_CYCLES+1).

Input handling:
- start while busy or in FINISH: ignored; no effect on the run.
- start in the cycle after FINISH (IDLE) is accepted normally.
- abort=1 while in HOLD: at the next edge go to IDLE, busy=0, vin=00, fail_vec=0, pass=0, no done.
- abort in IDLE has priority over start; the start is ignored.
- expected_tt changes during a run have no effect.
- gate_out is treated as synchronous to clk. The settle time must cover gate delay plus input-flop clock-to-q.
- SETTLE_CYCLES=0 is legal: each combination lasts one cycle and is sampled on the following edge.

Test Plan:
1. NOR model (gate_out = ~(vin1|vin2)), expected_tt=4'b0001, SETTLE_CYCLES=2, start at E0 -> vin sequence 00,01,10,11, each held 3 cycles; done pulse at E0+12; pass=1; fail_vec=0000.
2. AND model with expected_tt=4'b0001 -> mismatches at index 0 and 3; fail_vec=4'b1001; pass=0; done at E0+12.
3. start pulsed again at E0+5 during run 1 -> ignored; timing unchanged; single done pulse at E0+12.
4. rst_n low at E0+7 (mid-run) -> vin=00, busy=0, fail_vec=0, pass=0 immediately; no done; a later start runs a clean full sequence.
5. abort=1 at E0+4 -> IDLE at next edge; busy=0, vin=00, fail_vec=0, no done. Simultaneous start+abort in IDLE -> stays IDLE.
6. SETTLE_CYCLES=0 with XOR model and expected_tt=4'b0110 -> each combination held 1 cycle; done at E0+4; pass=1. Back-to-back start in the cycle after done -> second run accepted.
